// File: rtl/music_pkg.sv
// Shared encodings for the pinball music scheduler: note codes, track
// selections, sound-effect ids, FSM states and the effect priority picker.
package music_pkg;

   // Note index that the tone generator treats as silence
   localparam logic [4:0] S = 5'd0;

   // Background track selection as driven on bgm_sel
   typedef enum logic [1:0] {
      SEL_WAIT = 2'd0,
      SEL_PLAY = 2'd1,
      SEL_OVER = 2'd2,
      SEL_MUTE = 2'd3
   } sel_t;

   // Sound-effect ids; a lower id means a higher priority
   typedef enum logic [1:0] {
      SFX_BUMPER  = 2'd0,
      SFX_FLIPPER = 2'd1,
      SFX_SCORE   = 2'd2
   } sfx_id_t;

   // Scheduler state
   typedef enum logic [1:0] {
      ST_MUTE = 2'd0,
      ST_BGM  = 2'd1,
      ST_SFX  = 2'd2
   } state_t;

   // Highest-priority (lowest index) requested effect; bumper when none set
   function automatic logic [1:0] sfx_pick(input logic [2:0] req);
      logic [1:0] id;
      id = SFX_BUMPER;
      if (req[0])      id = SFX_BUMPER;
      else if (req[1]) id = SFX_FLIPPER;
      else if (req[2]) id = SFX_SCORE;
      return id;
   endfunction

endpackage

// File: rtl/music_scheduler_beat_divider.sv
// Beat divider: counts clk cycles 0..CLK_DIV-1 and raises a registered
// one-cycle tick while the count sits on its last value. A synchronous clear
// restarts the beat without producing a tick in that cycle.
module beat_divider #(
   parameter int CLK_DIV = 12_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic [CW-1:0] div_cnt_next;

   // Next count: a clear restarts the beat, otherwise wrap after the last cycle
   always_comb begin
      if (clear)                div_cnt_next = '0;
      else if (div_cnt == LAST) div_cnt_next = '0;
      else                      div_cnt_next = div_cnt + 1'b1;
   end

   // Count register; tick is registered so it is high exactly while the count is LAST
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         div_cnt <= div_cnt_next;
         tick    <= (div_cnt_next == LAST);
      end
   end

endmodule

// File: rtl/music_scheduler.sv
// Pinball music scheduler: beat timing, background beat counter, effect
// arbitration that pauses the background track, and the registered note mux.
// Effect support is built only when MUSIC_SFX_EN is defined; otherwise
// sfx_req is ignored and the effect outputs are held at zero.
module music_scheduler
   import music_pkg::*;
#(
   parameter int CLK_DIV = 12_500_000,
   parameter int BGM_LEN = 64,
   parameter int SFX_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  bgm_sel,
   input  logic [2:0]  sfx_req,
   input  logic [4:0]  note_wait,
   input  logic [4:0]  note_play,
   input  logic [4:0]  note_over,
   input  logic [4:0]  note_sfx,
   output logic [31:0] bgm_beat,
   output logic [31:0] sfx_beat,
   output logic [1:0]  sfx_id,
   output logic        sfx_busy,
   output logic        beat_tick,
   output logic [4:0]  note
);

   localparam logic [31:0] BGM_LAST = 32'(BGM_LEN - 1);

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] sel_q;
   logic       sel_chg;
   logic       accept;
   logic       sfx_exit;
   logic [4:0] note_next;

   assign sel_chg = (bgm_sel != sel_q);

   beat_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .clear (sel_chg | accept),
      .tick  (beat_tick)
   );

`ifdef MUSIC_SFX_EN
   localparam logic [31:0] SFX_LAST = 32'(SFX_LEN - 1);

   logic [1:0] req_id;

   // Accept a request when idle, or when it outranks the effect now playing;
   // leave the effect on the tick that ends its last beat
   always_comb begin
      req_id   = sfx_pick(sfx_req);
      accept   = (sfx_req != 3'b000) &&
                 ((state_reg != ST_SFX) || (req_id < sfx_id));
      sfx_exit = (state_reg == ST_SFX) && beat_tick &&
                 (sfx_beat == SFX_LAST) && !accept;
   end

   // Effect id and beat counter; an accepted request restarts at beat 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sfx_id   <= SFX_BUMPER;
         sfx_beat <= '0;
      end else if (accept) begin
         sfx_id   <= req_id;
         sfx_beat <= '0;
      end else if (sfx_exit) begin
         sfx_beat <= '0;
      end else if ((state_reg == ST_SFX) && beat_tick) begin
         sfx_beat <= sfx_beat + 32'd1;
      end
   end
`else
   logic unused_sfx_req;

   assign unused_sfx_req = ^sfx_req;
   assign accept         = 1'b0;
   assign sfx_exit       = 1'b0;
   assign sfx_id         = SFX_BUMPER;
   assign sfx_beat       = '0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_MUTE;
      else     state_reg <= state_next;
   end

   // Next state: effects take over; otherwise mute/background follows the new selection
   always_comb begin
      state_next = state_reg;
      if (accept)
         state_next = ST_SFX;
      else if ((state_reg == ST_SFX) && !sfx_exit)
         state_next = ST_SFX;
      else if (bgm_sel == SEL_MUTE)
         state_next = ST_MUTE;
      else
         state_next = ST_BGM;
   end

   // Outputs: busy flag and the note chosen for the next register stage
   always_comb begin
      sfx_busy  = (state_reg == ST_SFX);
      note_next = S;
      case (state_reg)
         ST_SFX: note_next = note_sfx;
         ST_BGM: begin
            case (sel_q)
               SEL_WAIT: note_next = note_wait;
               SEL_PLAY: note_next = note_play;
               SEL_OVER: note_next = note_over;
               default:  note_next = S;
            endcase
         end
         default: note_next = S;
      endcase
   end

   // Track selection, background beat (frozen outside BGM) and registered note
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q    <= SEL_MUTE;
         bgm_beat <= '0;
         note     <= S;
      end else begin
         sel_q <= bgm_sel;
         note  <= note_next;
         if (sel_chg)
            bgm_beat <= '0;
         else if ((state_reg == ST_BGM) && beat_tick)
            bgm_beat <= (bgm_beat == BGM_LAST) ? 32'd0 : bgm_beat + 32'd1;
      end
   end

endmodule

// File: tb/tb_music_scheduler.sv
// Self-checking bench for music_scheduler (CLK_DIV=4, BGM_LEN=8, SFX_LEN=3).
// A beat-level reference model predicts every output after each clock edge.
module tb_music_scheduler;

   localparam int CLK_DIV = 4;
   localparam int BGM_LEN = 8;
   localparam int SFX_LEN = 3;
`ifdef MUSIC_SFX_EN
   localparam bit SFX_EN = 1'b1;
`else
   localparam bit SFX_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  bgm_sel;
   logic [2:0]  sfx_req;
   logic [4:0]  note_wait, note_play, note_over, note_sfx;
   logic [31:0] bgm_beat, sfx_beat;
   logic [1:0]  sfx_id;
   logic        sfx_busy, beat_tick;
   logic [4:0]  note;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_sel, m_div, m_bgm, m_sb, m_id, m_note;
   bit m_tick, m_busy;

   music_scheduler #(
      .CLK_DIV (CLK_DIV),
      .BGM_LEN (BGM_LEN),
      .SFX_LEN (SFX_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bgm_sel   (bgm_sel),
      .sfx_req   (sfx_req),
      .note_wait (note_wait),
      .note_play (note_play),
      .note_over (note_over),
      .note_sfx  (note_sfx),
      .bgm_beat  (bgm_beat),
      .sfx_beat  (sfx_beat),
      .sfx_id    (sfx_id),
      .sfx_busy  (sfx_busy),
      .beat_tick (beat_tick),
      .note      (note)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("bgm_beat",  bgm_beat,  m_bgm);
      chk("sfx_beat",  sfx_beat,  m_sb);
      chk("sfx_id",    {30'd0, sfx_id},   m_id);
      chk("sfx_busy",  {31'd0, sfx_busy}, {31'd0, m_busy});
      chk("beat_tick", {31'd0, beat_tick}, {31'd0, m_tick});
      chk("note",      {27'd0, note},     m_note);
   endtask

   task automatic model_reset();
      m_sel = 3; m_div = 0; m_bgm = 0; m_sb = 0; m_id = 0; m_note = 0;
      m_tick = 0; m_busy = 0;
   endtask

   // One clock edge of the behavioural model, from the current inputs
   task automatic model_edge();
      bit chg, acc;
      int rid, nd;
      chg = (int'(bgm_sel) != m_sel);
      acc = 0;
      rid = 0;
      if (SFX_EN && sfx_req != 3'b000) begin
         for (int i = 2; i >= 0; i--)
            if (sfx_req[i]) rid = i;
         acc = !m_busy || (rid < m_id);
      end
      // note sees the pre-edge mode
      if (m_busy)           m_note = note_sfx;
      else if (m_sel == 0)  m_note = note_wait;
      else if (m_sel == 1)  m_note = note_play;
      else if (m_sel == 2)  m_note = note_over;
      else                  m_note = 0;
      // background beat runs only while playing a track with no effect
      if (chg)                                m_bgm = 0;
      else if (!m_busy && m_sel != 3 && m_tick) m_bgm = (m_bgm + 1) % BGM_LEN;
      // effect progress
      if (acc) begin
         m_busy = 1; m_id = rid; m_sb = 0;
      end else if (m_busy && m_tick) begin
         if (m_sb == SFX_LEN - 1) begin m_busy = 0; m_sb = 0; end
         else m_sb = m_sb + 1;
      end
      // beat timing
      nd     = (chg || acc) ? 0 : (m_div + 1) % CLK_DIV;
      m_div  = nd;
      m_tick = (nd == CLK_DIV - 1);
      m_sel  = int'(bgm_sel);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      note_wait = 5'($urandom_range(1, 31));
      note_play = 5'($urandom_range(1, 31));
      note_over = 5'($urandom_range(1, 31));
      note_sfx  = 5'($urandom_range(1, 31));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input logic [2:0] req);
      $display("req   sfx_req=%b bgm_beat=%0d sfx_id=%0d sfx_busy=%0d", req, m_bgm, m_id, m_busy);
      sfx_req = req;
      step();
      sfx_req = 3'b000;
   endtask

   task automatic set_sel(input logic [1:0] sel);
      $display("track bgm_sel=%0d at bgm_beat=%0d", sel, m_bgm);
      bgm_sel = sel;
   endtask

   // Advance until the model's background beat reaches target, within a cycle budget
   task automatic wait_bgm(input string tag, input int target, input int bound);
      bit reached;
      reached = (m_bgm == target);
      for (int i = 0; i < bound && !reached; i++) begin
         step();
         reached = (m_bgm == target);
      end
      chk(tag, {31'd0, reached}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      bgm_sel = 2'd0;
      sfx_req = 3'b000;
      note_wait = 5'd3; note_play = 5'd7; note_over = 5'd11; note_sfx = 5'd19;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // WAIT track: beat every 4 clocks, wrap at 8
      run(40);

      // Switch to PLAY at beat 5
      wait_bgm("wait_beat5", 5, 64);
      set_sel(2'd1);
      run(12);

      // Flipper+score at beat 3: flipper wins, background frozen
      wait_bgm("wait_beat3", 3, 64);
      pulse(3'b110);
      run(5);                 // now in sfx beat 1
      pulse(3'b100);          // lower priority: ignored
      run(2);
      pulse(3'b001);          // bumper outranks flipper: restart
      run(20);

      // Mute, then an effect inside mute
      set_sel(2'd3);
      run(10);
      pulse(3'b100);
      run(16);

      // Reset in the middle of an effect at sfx beat 2
      set_sel(2'd1);
      run(6);
      pulse(3'b010);
      run(8);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      bgm_sel = 2'd2;
      @(negedge clk);
      rst = 1'b0;
      run(20);

      // Random track changes and effect requests
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) set_sel(2'($urandom_range(0, 3)));
         if ($urandom_range(0, 7) == 0) pulse(3'($urandom_range(1, 7)));
         else step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/music_scheduler.md
Name: music_scheduler

Overview:
- Sequences the pinball sound system.
- Generates beat timing and drives beat counters into the combinational note-lookup tracks (wait, play, game-over background tracks, plus sound-effect tracks).
- Arbitrates short sound effects against the background track, pausing and resuming it.
- Delivers one registered 5-bit note index to the tone generator.

Parameters:
- CLK_DIV, 12_500_000: clk cycles per beat (8 beats/s at 100 MHz); must be ≥2.
- BGM_LEN, 64: background loop length in beats; bgm_beat wraps BGM_LEN-1 → 0.
- SFX_LEN, 4: beats per sound effect.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- bgm_sel  in  2  background track: 0=WAIT, 1=PLAY, 2=OVER, 3=mute.
- sfx_req  in  3  one-cycle effect requests; bit0 bumper (highest priority), bit1 flipper, bit2 score.
- note_wait  in  5  note from WAIT track lookup.
- note_play  in  5  note from PLAY track lookup.
- note_over  in  5  note from OVER track lookup.
- note_sfx  in  5  note from effect lookup (indexed by sfx_id, sfx_beat).
- bgm_beat  out  32  beat index to background lookups.
- sfx_beat  out  32  beat index to effect lookup.
- sfx_id  out  2  active effect (0..2).
- sfx_busy  out  1  effect in progress.
- beat_tick  out  1  one-cycle pulse at each beat boundary.
- note  out  5  registered note index; 0 = silence (S).

Behaviour:
- Reset (async): all counters 0, state MUTE, note=0, bgm_beat=0, sfx_beat=0, sfx_id=0, sfx_busy=0, beat_tick=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - beat_tick=1 in the cycle div_cnt==CLK_DIV-1; div_cnt then wraps to 0.
  - beat_tick is registered.
- Track change: bgm_sel is registered as sel_q. When bgm_sel≠sel_q, the next edge sets sel_q, bgm_beat=0 and div_cnt=0; no tick occurs that cycle.
- States:
  - MUTE: sel_q==3 and no effect.
  - BGM: sel_q∈{0,1,2} and no effect.
  - SFX: effect playing.
- Transitions:
  - MUTE↔BGM follows sel_q.
  - Any state → SFX on an accepted request.
  - SFX → BGM/MUTE (per sel_q) on the tick where sfx_beat==SFX_LEN-1.
- BGM: bgm_beat increments on each beat_tick; wraps BGM_LEN-1 → 0.
- SFX:
  - On acceptance: sfx_id = highest-priority set bit, sfx_beat=0, sfx_busy=1, div_cnt=0.
  - sfx_beat increments per tick.
  - bgm_beat is frozen during SFX and resumes from its frozen value on exit.
  - On exit: sfx_busy=0 and sfx_beat=0 in the same edge.
- Arbitration:
  - Simultaneous requests: lowest bit index wins; other bits are dropped, not queued.
  - Request during SFX: accepted only if strictly higher priority (lower index) than sfx_id; the effect restarts at beat 0.
  - Equal or lower priority requests are ignored.
- Simultaneous track change and effect request: both apply. bgm_beat=0, sel_q updated, effect starts.
- Note mux:
  - Selects note_sfx in SFX, else the note input per sel_q; 0 in MUTE.
  - Registered: note reflects inputs with 1-clk latency.
  - Lookups see the updated beat index the cycle after it changes.
- Reset asserted mid-effect or mid-beat: immediate return to reset values; no resume.

Optional Feature:
- Macro: MUSIC_SFX_EN.
- Defined: effect arbitration and the SFX state are present, as described.
- Undefined:
  - sfx_req ignored; SFX state absent.
  - sfx_busy=0, sfx_id=0, sfx_beat=0 constant; note_sfx unused.
  - Background tracks are never paused.

Decomposition:
- Package music_pkg holds:
  - note code constant S=0.
  - bgm_sel encodings (SEL_WAIT, SEL_PLAY, SEL_OVER, SEL_MUTE).
  - sfx ids (SFX_BUMPER=0, SFX_FLIPPER=1, SFX_SCORE=2).
  - FSM state encoding (ST_MUTE, ST_BGM, ST_SFX).
- One sub-module, beat_divider: div_cnt with sync clear input and beat_tick output, parameter CLK_DIV.

Test Plan:
Bench parameters: CLK_DIV=4, BGM_LEN=8, SFX_LEN=3.
- Reset, then bgm_sel=0 for 40 clk → beat_tick every 4 clk; bgm_beat 0,1..7,0,1,2; note = note_wait delayed 1 clk.
- bgm_sel 0→1 at bgm_beat=5 → next edge bgm_beat=0, div restarts, first tick 4 clk later; note follows note_play.
- At bgm_beat=3, pulse sfx_req=3'b110 → sfx_id=1, sfx_busy=1, note=note_sfx; bgm_beat held at 3 for 3 beats, then resumes 3→4.
- During sfx_id=1 at sfx_beat=1: sfx_req=3'b100 → ignored. Then sfx_req=3'b001 → sfx_id=0, sfx_beat=0, full 3 beats played.
- bgm_sel=3 → note=0, bgm_beat stays 0. Effect request in mute plays, then returns to note=0.
- Assert rst mid-effect at sfx_beat=2 → all outputs 0 immediately (async); after release, MUTE/BGM per bgm_sel from beat 0.
